// File: rtl/intt_scale_control_pkg.sv
// Shared FHE ALU definitions for the post-iNTT scaling stage: geometry constants,
// controller state encoding and the configuration latched at each start.
package intt_scale_control_pkg;

    localparam int FSIZE_W = 64;
    localparam int E_W     = 8;
    localparam int LOGN_W  = 16;
    localparam int LOG_E   = $clog2(E_W);
    localparam int ROW_AW  = LOGN_W - LOG_E;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [FSIZE_W-1:0] p;
        logic [FSIZE_W-1:0] n_inv;
        logic [FSIZE_W-1:0] n_inv_q;
        logic [LOG_E-1:0]   diff_logN;
    } cfg_t;

    // Index of the last row to scale for a given ring shrink, clamped at row 0.
    function automatic logic [ROW_AW-1:0] last_row(input logic [LOG_E-1:0] diff_logN);
        logic [ROW_AW:0] rows;
        rows = {1'b1, {ROW_AW{1'b0}}} >> diff_logN;
        if (rows == '0) begin
            return '0;
        end
        return ROW_AW'(rows - 1'b1);
    endfunction

endpackage

// File: rtl/intt_scale_control_shoup_mulmod.sv
// One lane of a MUL_LAT-deep Shoup modular multiplier: y = a * n_inv mod p.
// Defining INTT_SCALE_LAZY_EN drops the final conditional subtraction (y in [0, 2p)).
module intt_scale_control_shoup_mulmod #(
    parameter int FSIZE   = 64,
    parameter int MUL_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [FSIZE-1:0] a,
    input  logic [FSIZE-1:0] n_inv,
    input  logic [FSIZE-1:0] n_inv_q,
    input  logic [FSIZE-1:0] p,
    output logic [FSIZE-1:0] y
);

    localparam int PAD = MUL_LAT - 1;

    logic [FSIZE-1:0] q_s  [PAD];
    logic [FSIZE-1:0] an_s [PAD];
    logic [FSIZE-1:0] r;
    logic [FSIZE-1:0] y_next;

    // NOTE: the data pipeline carries no reset; only the output register must
    // come out of reset clean, and validity travels in the controller's tag pipeline.
    always_ff @(posedge clk) begin
        q_s[0]  <= FSIZE'(({{FSIZE{1'b0}}, a} * {{FSIZE{1'b0}}, n_inv_q}) >> FSIZE);
        an_s[0] <= a * n_inv;
        for (int j = 1; j < PAD; j++) begin
            q_s[j]  <= q_s[j-1];
            an_s[j] <= an_s[j-1];
        end
    end

    // Low-word difference is exact because the true remainder lies in [0, 2p).
    assign r = an_s[PAD-1] - q_s[PAD-1] * p;

`ifdef INTT_SCALE_LAZY_EN
    assign y_next = r;
`else
    assign y_next = (r >= p) ? r - p : r;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            y <= '0;
        end else if (en) begin
            y <= y_next;
        end
    end

endmodule

// File: rtl/intt_scale_control.sv
// Post-iNTT scaler: re-reads every buffer row, multiplies each coefficient by n_inv mod p
// and writes it back in place. Macro INTT_SCALE_LAZY_EN selects lazy [0, 2p) outputs.
module intt_scale_control
    import intt_scale_control_pkg::*;
#(
    parameter int FSIZE    = FSIZE_W,
    parameter int E        = E_W,
    parameter int LOGN     = LOGN_W,
    parameter int READ_LAT = 2,
    parameter int MUL_LAT  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [FSIZE-1:0]              p,
    input  logic [FSIZE-1:0]              n_inv,
    input  logic [FSIZE-1:0]              n_inv_q,
    input  logic [$clog2(E)-1:0]          diff_logN,
    output logic                          busy,
    output logic                          done,
    output logic [LOGN-$clog2(E)-1:0]     ram_raddr,
    input  logic [E*FSIZE-1:0]            ram_rdata,
    output logic                          ram_wren,
    output logic [LOGN-$clog2(E)-1:0]     ram_waddr,
    output logic [E*FSIZE-1:0]            ram_wdata
);

    localparam int AW    = LOGN - $clog2(E);
    localparam int DEPTH = READ_LAT + MUL_LAT;

    state_t           state;
    cfg_t             cfg;
    logic [AW-1:0]    rd_idx;
    logic [AW-1:0]    last_idx;
    logic [DEPTH-1:0] tag_valid;
    logic [AW-1:0]    tag_addr [DEPTH];

    assign last_idx  = last_row(cfg.diff_logN);
    assign ram_raddr = rd_idx;
    assign ram_wren  = tag_valid[DEPTH-1];
    assign ram_waddr = tag_addr[DEPTH-1];

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rd_idx <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        rd_idx <= '0;
                        busy   <= 1'b1;
                        cfg    <= '{p: p, n_inv: n_inv, n_inv_q: n_inv_q, diff_logN: diff_logN};
                    end
                end
                RUN: begin
                    if (rd_idx == last_idx) begin
                        state  <= DRAIN;
                        rd_idx <= '0;
                    end else begin
                        rd_idx <= rd_idx + 1'b1;
                    end
                end
                DRAIN: begin
                    // Last write is on the bus and nothing follows it.
                    if (tag_valid[DEPTH-1] && (tag_valid[DEPTH-2:0] == '0)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_addr[i] <= '0;
            end
        end else begin
            tag_valid   <= {tag_valid[DEPTH-2:0], state == RUN};
            tag_addr[0] <= rd_idx;
            for (int i = 1; i < DEPTH; i++) begin
                tag_addr[i] <= tag_addr[i-1];
            end
        end
    end

    for (genvar i = 0; i < E; i++) begin : g_lane
        intt_scale_control_shoup_mulmod #(
            .FSIZE   (FSIZE),
            .MUL_LAT (MUL_LAT)
        ) u_mulmod (
            .clk     (clk),
            .rst     (rst),
            .en      (tag_valid[DEPTH-2]),
            .a       (ram_rdata[FSIZE*i +: FSIZE]),
            .n_inv   (cfg.n_inv),
            .n_inv_q (cfg.n_inv_q),
            .p       (cfg.p),
            .y       (ram_wdata[FSIZE*i +: FSIZE])
        );
    end

endmodule

// File: tb/tb_intt_scale_control.sv
// Bench for intt_scale_control: buffer RAM model, cycle-timeline model with a golden
// a*n_inv mod p reference, and directed runs. Honours INTT_SCALE_LAZY_EN.
module tb_intt_scale_control;

    localparam int F    = 64;
    localparam int E    = 8;
    localparam int LOGN = 16;
    localparam int RL   = 2;
    localparam int ML   = 4;
    localparam int LAT  = RL + ML;
    localparam int AW   = 13;
    localparam int NROW = 8192;
    localparam int W    = E * F;
`ifdef INTT_SCALE_LAZY_EN
    localparam bit LAZY = 1'b1;
`else
    localparam bit LAZY = 1'b0;
`endif
    localparam logic [63:0] P61 = 64'h1FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] N61 = 64'h0001_0000_0000_0000;

    logic          clk, rst, start, busy, done, ram_wren;
    logic [F-1:0]  p_in, n_in, nq_in;
    logic [2:0]    diff_in;
    logic [AW-1:0] ram_raddr, ram_waddr;
    logic [W-1:0]  ram_rdata, ram_wdata;

    intt_scale_control #(
        .FSIZE(F), .E(E), .LOGN(LOGN), .READ_LAT(RL), .MUL_LAT(ML)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .p(p_in), .n_inv(n_in), .n_inv_q(nq_in),
        .diff_logN(diff_in), .busy(busy), .done(done), .ram_raddr(ram_raddr),
        .ram_rdata(ram_rdata), .ram_wren(ram_wren), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer RAM with READ_LAT read latency and a bench preload port
    logic [W-1:0]  mem     [NROW];
    logic [W-1:0]  src_mem [NROW];
    logic [W-1:0]  rd_pipe [RL];
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [W-1:0]  ld_data;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (ram_wren) mem[ram_waddr] <= ram_wdata;
        rd_pipe[0] <= mem[ram_raddr];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[RL-1];

    int checks = 0;
    int errors = 0;
    bit run_active;
    int run_cyc, run_rows, wren_cnt, done_cyc;
    logic [63:0] run_p, run_n;

    function automatic logic [63:0] mod_mul(input logic [63:0] a, input logic [63:0] n,
                                            input logic [63:0] pm);
        logic [127:0] t;
        t = {64'd0, a} * {64'd0, n};
        t = t % {64'd0, pm};
        return t[63:0];
    endfunction

    function automatic logic [63:0] shoup_q(input logic [63:0] n, input logic [63:0] pm);
        logic [127:0] t;
        t = {n, 64'd0} / {64'd0, pm};
        return t[63:0];
    endfunction

    function automatic logic [W-1:0] golden_row(input logic [W-1:0] src, input logic [63:0] n,
                                                input logic [63:0] pm);
        logic [W-1:0] r;
        for (int i = 0; i < E; i++) r[F*i +: F] = mod_mul(src[F*i +: F], n, pm);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Row compare; in lazy builds a lane may also equal expected + p.
    task automatic check_row(input string name, input logic [W-1:0] act, input logic [W-1:0] expv,
                             input logic [63:0] pm);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < E; i++) begin
            if (!(act[F*i +: F] === expv[F*i +: F] ||
                  (LAZY && act[F*i +: F] === expv[F*i +: F] + pm))) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Timeline model: cycle c counts from the first cycle after an accepted start.
    always @(posedge clk) begin : cmp
        int c, k;
        #1;
        if (run_active) begin
            run_cyc = run_cyc + 1;
            c = run_cyc;
            k = c - LAT;
            if (ram_wren) wren_cnt++;
            if (done) done_cyc = c;
            check("busy", 64'(busy), 64'(c <= run_rows + LAT));
            check("done", 64'(done), 64'(c == run_rows + LAT));
            check("wren", 64'(ram_wren), 64'(k >= 0 && k < run_rows));
            if (c < run_rows) check("raddr", 64'(ram_raddr), 64'(c));
            if (k >= 0 && k < run_rows) begin
                check("waddr", 64'(ram_waddr), 64'(k));
                check_row("wdata", ram_wdata, golden_row(src_mem[k], run_n, run_p), run_p);
            end
            if (c >= run_rows + LAT + 1) run_active = 1'b0;
        end else begin
            check("idle_wren", 64'(ram_wren), 64'd0);
            check("idle_done", 64'(done), 64'd0);
        end
    end

    task automatic preload_fill(input int rows, input bit rnd, input logic [63:0] val,
                                input logic [63:0] pm);
        for (int r = 0; r < rows; r++) begin
            logic [W-1:0] d;
            for (int i = 0; i < E; i++) d[F*i +: F] = rnd ? ({$urandom, $urandom} % pm) : val;
            @(negedge clk);
            ld_en = 1'b1; ld_addr = AW'(r); ld_data = d;
        end
        @(negedge clk);
        ld_en = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; start is held for exactly one cycle.
    task automatic launch(input logic [2:0] diff, input logic [63:0] pm, input logic [63:0] n);
        run_rows = NROW >> diff;
        run_p = pm; run_n = n;
        for (int r = 0; r < run_rows; r++) src_mem[r] = mem[r];
        p_in = pm; n_in = n; nq_in = shoup_q(n, pm); diff_in = diff;
        wren_cnt = 0; done_cyc = -1; run_cyc = -1; run_active = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n;
        n = 0;
        while (run_active && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("run_finished", 64'(run_active), 64'd0);
        run_active = 1'b0;
    endtask

    task automatic wait_cyc(input int target, input int budget);
        int n;
        n = 0;
        while (run_cyc != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("cycle_reached", 64'(run_cyc), 64'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_wren"}, 64'(ram_wren), 64'd0);
        check({tag, "_raddr"}, 64'(ram_raddr), 64'd0);
        check({tag, "_waddr"}, 64'(ram_waddr), 64'd0);
        check_row({tag, "_wdata"}, ram_wdata, '0, 64'd0);
    endtask

    initial begin
        logic [W-1:0] row_exp;
        rst = 1'b1; start = 1'b0; p_in = '0; n_in = '0; nq_in = '0; diff_in = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        run_active = 1'b0; run_cyc = 0; run_rows = 0; wren_cnt = 0; done_cyc = -1;
        run_p = '0; run_n = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Pin the reference model with hand-computed values
        check("pin_16x91", mod_mul(64'd16, 64'd91, 64'd97), 64'd1);
        check("pin_96x91", mod_mul(64'd96, 64'd91, 64'd97), 64'd6);
        check("pin_2x91", mod_mul(64'd2, 64'd91, 64'd97), 64'd85);
        check("pin_p61", mod_mul(64'd8192, N61, P61), 64'd1);

        // Smallest pass: 64 rows of 16s, scaled by 16^-1 mod 97
        preload_fill(65, 1'b0, 64'd16, 64'd97);
        launch(3'd7, 64'd97, 64'd91);
        wait_end(300);
        check("done_latency", 64'(done_cyc), 64'd70);
        check("writes_r1", 64'(wren_cnt), 64'd64);
        check_row("ones_row0", mem[0], {E{64'd1}}, 64'd97);
        check_row("ones_row63", mem[63], {E{64'd1}}, 64'd97);
        check_row("untouched_row64", mem[64], {E{64'd16}}, 64'd0);

        // Reduction edges in row 0; remaining rows hold ones
        @(negedge clk);
        ld_en = 1'b1; ld_addr = '0;
        ld_data = {64'd2, 64'd95, 64'd32, 64'd16, 64'd48, 64'd96, 64'd1, 64'd0};
        @(negedge clk);
        ld_en = 1'b0;
        @(negedge clk);
        launch(3'd7, 64'd97, 64'd91);
        wait_end(300);
        row_exp = {64'd85, 64'd12, 64'd2, 64'd1, 64'd3, 64'd6, 64'd91, 64'd0};
        check_row("edge_row0", mem[0], row_exp, 64'd97);
        check_row("edge_row1", mem[1], {E{64'd91}}, 64'd97);

        // Back-to-back start, with an ignored start and config churn in RUN cycle 5
        launch(3'd7, 64'd97, 64'd91);
        wait_cyc(5, 50);
        start = 1'b1; p_in = 64'd101; n_in = 64'd5; nq_in = 64'd1;
        @(negedge clk);
        start = 1'b0;
        wait_end(300);
        check("writes_ignored_start", 64'(wren_cnt), 64'd64);

        // Reset in the third DRAIN cycle, then a fresh pass
        @(negedge clk);
        launch(3'd7, 64'd97, 64'd91);
        wait_cyc(64 + 2, 200);
        rst = 1'b1;
        run_active = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midrst");
        repeat (4) @(negedge clk);
        launch(3'd7, 64'd97, 64'd91);
        wait_end(300);
        check("writes_after_reset", 64'(wren_cnt), 64'd64);

        // Full-size sweep over random data modulo 2^61-1
        preload_fill(NROW, 1'b1, 64'd0, P61);
        launch(3'd0, P61, N61);
        wait_end(9000);
        check("writes_full", 64'(wren_cnt), 64'(NROW));

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
